normalizing_unit: RTL and testbench

Post-addition normalizer of the 32-bit IEEE-754 single-precision adder. It takes the raw 24-bit significand sum (hidden bit included), the adder's carry-out and the common biased exponent. It produces a registered, normalized significand/exponent pair for the rounding/packing stage. Right-shift on carry, leading-zero left-shift otherwise, with overflow-to-infinity and gradual-underflow handling.

---
 rtl/normalizing_unit_pkg.sv | 10 +
 rtl/normalizing_unit_lzc24.sv | 21 ++
 rtl/normalizing_unit.sv | 69 ++++++
 tb/tb_normalizing_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/normalizing_unit_pkg.sv
// Shared single-precision FP constants used by the adder datapath stages.
package normalizing_unit_pkg;

    localparam int unsigned MANT_W        = 24;
    localparam int unsigned EXP_W         = 8;
    localparam int unsigned LZC_W         = 5;
    localparam logic [7:0]  EXP_MAX       = 8'd255;
    localparam logic [7:0]  EXP_OVF_LIMIT = 8'd254;

endpackage

// File: rtl/normalizing_unit_lzc24.sv
// Combinational 24-bit leading-zero counter; count reads 24 and zero_o is set for a zero input.
module lzc24
    import normalizing_unit_pkg::*;
(
    input  logic [MANT_W-1:0] data_i,
    output logic [LZC_W-1:0]  count_o,
    output logic              zero_o
);

    always_comb begin
        count_o = LZC_W'(MANT_W);
        zero_o  = (data_i == '0);
        // Ascending scan so the most significant set bit wins the priority.
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (data_i[i]) begin
                count_o = LZC_W'(int'(MANT_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/normalizing_unit.sv
// Post-addition normalizer: carry right-shift, leading-zero left-shift, overflow and underflow.
module normalizing_unit
    import normalizing_unit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              enable,
    input  logic              carry,
    input  logic [MANT_W-1:0] mantissa,
    input  logic [EXP_W-1:0]  exponent,
    output logic [MANT_W-1:0] mantissa_normalized,
    output logic [EXP_W-1:0]  exponent_normalized
);

    logic [LZC_W-1:0]  lz;
    logic              mant_zero;
    logic [EXP_W-1:0]  lz_ext;
    logic [EXP_W-1:0]  sh;
    logic [MANT_W-1:0] mant_d, mant_q;
    logic [EXP_W-1:0]  exp_d, exp_q;

    lzc24 u_lzc (
        .data_i  (mantissa),
        .count_o (lz),
        .zero_o  (mant_zero)
    );

    assign lz_ext = {3'b000, lz};

    always_comb begin
        mant_d = '0;
        exp_d  = '0;
        sh     = '0;
        if (carry) begin
            if (exponent >= EXP_OVF_LIMIT) begin
                mant_d = '0;
                exp_d  = EXP_MAX;
            end else begin
                mant_d = {1'b1, mantissa[MANT_W-1:1]};
                exp_d  = exponent + 8'd1;
            end
        end else if (mant_zero) begin
            mant_d = '0;
            exp_d  = '0;
        end else if (lz_ext < exponent) begin
            mant_d = mantissa << lz;
            exp_d  = exponent - lz_ext;
        end else begin
            // Shift only as far as the denormal exponent allows (exponent 0 and 1 share scale).
            sh     = (exponent == '0) ? '0 : exponent - 8'd1;
            mant_d = mantissa << sh;
            exp_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mant_q <= '0;
            exp_q  <= '0;
        end else if (enable) begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
        end
    end

    assign mantissa_normalized = mant_q;
    assign exponent_normalized = exp_q;

endmodule

// File: tb/tb_normalizing_unit.sv
// Scoreboard bench for normalizing_unit: directed spec vectors plus randomized model vectors.
module tb_normalizing_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        enable = 1'b0;
    logic        carry = 1'b0;
    logic [23:0] mantissa = '0;
    logic [7:0]  exponent = '0;
    logic [23:0] mantissa_normalized;
    logic [7:0]  exponent_normalized;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] want;
    logic [31:0] got;

    normalizing_unit dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .enable              (enable),
        .carry               (carry),
        .mantissa            (mantissa),
        .exponent            (exponent),
        .mantissa_normalized (mantissa_normalized),
        .exponent_normalized (exponent_normalized)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] model(input logic c, input logic [23:0] m,
                                          input logic [7:0] e);
        int lz;
        logic [23:0] mm;
        if (c) begin
            if (e >= 8'd254) return {24'h000000, 8'hFF};
            return {1'b1, m[23:1], e + 8'd1};
        end
        if (m == 24'h0) return 32'h0;
        lz = 0;
        mm = m;
        while (!mm[23]) begin
            mm = mm << 1;
            lz++;
        end
        if (lz < int'(e)) return {mm, 8'(int'(e) - lz)};
        if (e == 8'd0) return {m, 8'h00};
        return {m << (int'(e) - 1), 8'h00};
    endfunction

    // Drive one operand set, push its expected result, clock it in, sample #1 later.
    task automatic load(input logic c, input logic [23:0] m, input logic [7:0] e,
                        input logic [31:0] expv);
        carry    = c;
        mantissa = m;
        exponent = e;
        enable   = 1'b1;
        exp_q.push_back(expv);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        load(1'b0, 24'h080000, 8'd127, 32'h80000000 | 32'd123);
        want = exp_q.pop_front();
        got  = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== want) $display("FAIL reset_preload got %h want %h", got, want);
        else n_pass++;
        @(negedge Clk);
        carry    = 1'b1;
        mantissa = 24'hABCDEF;
        exponent = 8'd77;
        Reset    = 1'b0;
        #1;
        got = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== 32'h0) $display("FAIL reset_async got %h want %h", got, 32'h0);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            got = {mantissa_normalized, exponent_normalized};
            n_total++;
            if (got !== 32'h0) $display("FAIL reset_hold got %h want %h", got, 32'h0);
            else n_pass++;
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] vc[8];
        logic [23:0] vm[8];
        logic [7:0]  ve[8];
        logic [31:0] vw[8];
        vc = '{0, 1, 0, 0, 1, 0, 0, 1};
        vm = '{24'h080000, 24'h080000, 24'h000001, 24'h000001, 24'h123456, 24'h000000,
               24'hC00000, 24'h000001};
        ve = '{8'd127, 8'd30, 8'd30, 8'd10, 8'd254, 8'd100, 8'd5, 8'd253};
        vw = '{{24'h800000, 8'd123}, {24'h840000, 8'd31}, {24'h800000, 8'd7},
               {24'h000200, 8'd0}, {24'h000000, 8'd255}, {24'h000000, 8'd0},
               {24'hC00000, 8'd5}, {24'h800000, 8'd254}};
        for (int i = 0; i < 8; i++) begin
            load(vc[i][0], vm[i], ve[i], vw[i]);
            want = exp_q.pop_front();
            got  = {mantissa_normalized, exponent_normalized};
            n_total++;
            if (got !== want) $display("FAIL directed_%0d got %h want %h", i, got, want);
            else n_pass++;
        end
        // Underflow edge cases with exponent 0 and 1: no shift allowed.
        load(1'b0, 24'h000100, 8'd0, {24'h000100, 8'd0});
        want = exp_q.pop_front();
        got  = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== want) $display("FAIL underflow_e0 got %h want %h", got, want);
        else n_pass++;
        load(1'b0, 24'h400000, 8'd1, {24'h400000, 8'd0});
        want = exp_q.pop_front();
        got  = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== want) $display("FAIL underflow_e1 got %h want %h", got, want);
        else n_pass++;
    endtask

    task automatic test_enable_hold();
        load(1'b0, 24'h080000, 8'd127, {24'h800000, 8'd123});
        want = exp_q.pop_front();
        got  = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== want) $display("FAIL hold_load got %h want %h", got, want);
        else n_pass++;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            carry    = 1'($urandom);
            mantissa = 24'($urandom);
            exponent = 8'($urandom);
            @(posedge Clk);
            #1;
            got = {mantissa_normalized, exponent_normalized};
            n_total++;
            if (got !== {24'h800000, 8'd123})
                $display("FAIL hold_cycle_%0d got %h want %h", i, got, {24'h800000, 8'd123});
            else n_pass++;
        end
        #2;
        Reset = 1'b0;
        #1;
        got = {mantissa_normalized, exponent_normalized};
        n_total++;
        if (got !== 32'h0) $display("FAIL hold_reset got %h want %h", got, 32'h0);
        else n_pass++;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic        c;
        logic [23:0] m;
        logic [7:0]  e;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 3) == 0);
            m = 24'($urandom) >> $urandom_range(0, 24);
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(0, 24));
                1:       e = 8'($urandom_range(250, 255));
                default: e = 8'($urandom);
            endcase
            load(c, m, e, model(c, m, e));
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL b2b_queue_empty got %0d want %0d", 0, 1);
            end else begin
                want = exp_q.pop_front();
                got  = {mantissa_normalized, exponent_normalized};
                n_total++;
                if (got !== want)
                    $display("FAIL b2b_%0d c=%0b m=%h e=%0d got %h want %h",
                             i, c, m, e, got, want);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_directed();
        test_enable_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
